// File: rtl/camera_pkg.sv
// Shared types and default parameters for the camera deserializer.
package camera_pkg;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_BYTES_PER_PIX = 2;
  localparam int DEF_HCOUNT_W      = 11;
  localparam int DEF_VCOUNT_W      = 10;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_FRAME      = 2'd1,
    ST_LINE       = 2'd2
  } cam_state_e;

endpackage

// File: rtl/camera_deser_if.sv
// Pixel output bus of camera_deser; stats ports exist only with CAMERA_DESER_STATS_EN.
interface camera_deser_if
  import camera_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BYTES_PER_PIX = DEF_BYTES_PER_PIX,
  parameter int HCOUNT_W      = DEF_HCOUNT_W,
  parameter int VCOUNT_W      = DEF_VCOUNT_W
) ();

  logic [DATA_W*BYTES_PER_PIX-1:0] data_out;
  logic                            valid_out;
  logic [HCOUNT_W-1:0]             hcount_out;
  logic [VCOUNT_W-1:0]             vcount_out;
  logic                            frame_start_out;
  logic                            line_end_out;
  logic                            sync_err_out;
`ifdef CAMERA_DESER_STATS_EN
  logic [HCOUNT_W-1:0]             line_len_out;
  logic [VCOUNT_W-1:0]             frame_lines_out;
`endif

  modport master (
    output data_out, valid_out, hcount_out, vcount_out,
    output frame_start_out, line_end_out, sync_err_out
`ifdef CAMERA_DESER_STATS_EN
    , output line_len_out, frame_lines_out
`endif
  );

  modport slave (
    input data_out, valid_out, hcount_out, vcount_out,
    input frame_start_out, line_end_out, sync_err_out
`ifdef CAMERA_DESER_STATS_EN
    , input line_len_out, frame_lines_out
`endif
  );

endinterface

// File: rtl/cam_sync.sv
// STAGES-deep flop chain bringing the camera signals into the system clock domain.
module cam_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_r;

  // Shift the sampled inputs down the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= '0;
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/camera_deser.sv
// Camera byte-bus deserializer: assembles pixels and tracks line/frame position.
// Optional line/frame statistics outputs are enabled by CAMERA_DESER_STATS_EN.
module camera_deser
  import camera_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BYTES_PER_PIX = DEF_BYTES_PER_PIX,
  parameter int HCOUNT_W      = DEF_HCOUNT_W,
  parameter int VCOUNT_W      = DEF_VCOUNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic              pclk_cam_in,
  input  logic              hs_cam_in,
  input  logic              vs_cam_in,
  input  logic [DATA_W-1:0] data_cam_in,
  camera_deser_if.master    pix
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int SW    = DATA_W + 4;

  logic [SW-1:0]       sync_in_s, sync_out_s;
  logic                live_r, pclk_r, hs_r, vs_r, pclk_d_r, vs_d_r, armed_r;
  logic [DATA_W-1:0]   byte_r;
  logic                pclk_rise_s, vs_rise_s, vs_fall_s;
  cam_state_e          state_r;
  logic [1:0]          byte_idx_r;
  logic [HCOUNT_W-1:0] hcnt_r, hcnt_inc_s;
  logic [VCOUNT_W-1:0] vcnt_r, vcnt_inc_s;
  logic [PIX_W-1:0]    pix_r, pix_next_s;
  logic                store_s, end_line_s, last_byte_s;

  // The constant '1' marks when real samples have reached the chain output after reset.
  assign sync_in_s = {1'b1, pclk_cam_in, hs_cam_in, vs_cam_in, data_cam_in};

  cam_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_pixel_in),
    .rst (rst_in),
    .d   (sync_in_s),
    .q   (sync_out_s)
  );

  // Edge-detect stage; armed_r requires a genuine vs low before any frame may start.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      {live_r, pclk_r, hs_r, vs_r, byte_r} <= '0;
      pclk_d_r <= 1'b0;
      vs_d_r   <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      {live_r, pclk_r, hs_r, vs_r, byte_r} <= sync_out_s;
      pclk_d_r <= pclk_r;
      vs_d_r   <= vs_r;
      armed_r  <= armed_r | (live_r & ~vs_r);
    end
  end

  assign pclk_rise_s = pclk_r & ~pclk_d_r;
  assign vs_rise_s   = armed_r & vs_r & ~vs_d_r;
  assign vs_fall_s   = vs_d_r & ~vs_r;

  // Byte placement, saturating counters and per-state store/line-end decode.
  always_comb begin
    pix_next_s = pix_r;
    pix_next_s[(BYTES_PER_PIX - 1 - int'(byte_idx_r)) * DATA_W +: DATA_W] = byte_r;
    last_byte_s = (byte_idx_r == 2'(BYTES_PER_PIX - 1));
    hcnt_inc_s  = (hcnt_r == {HCOUNT_W{1'b1}}) ? hcnt_r : hcnt_r + HCOUNT_W'(1'b1);
    vcnt_inc_s  = (vcnt_r == {VCOUNT_W{1'b1}}) ? vcnt_r : vcnt_r + VCOUNT_W'(1'b1);
    store_s     = 1'b0;
    end_line_s  = 1'b0;
    case (state_r)
      ST_FRAME: begin
        store_s = ~vs_fall_s & pclk_rise_s & hs_r & vs_r;
      end
      ST_LINE: begin
        store_s    = ~vs_fall_s & pclk_rise_s & hs_r;
        end_line_s = vs_fall_s | (pclk_rise_s & ~hs_r);
      end
      default: begin
        store_s    = 1'b0;
        end_line_s = 1'b0;
      end
    endcase
  end

  // Frame/line FSM with pixel assembly and registered output bus.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state_r             <= ST_WAIT_FRAME;
      byte_idx_r          <= 2'd0;
      hcnt_r              <= '0;
      vcnt_r              <= '0;
      pix_r               <= '0;
      pix.data_out        <= '0;
      pix.valid_out       <= 1'b0;
      pix.hcount_out      <= '0;
      pix.vcount_out      <= '0;
      pix.frame_start_out <= 1'b0;
      pix.line_end_out    <= 1'b0;
      pix.sync_err_out    <= 1'b0;
`ifdef CAMERA_DESER_STATS_EN
      pix.line_len_out    <= '0;
      pix.frame_lines_out <= '0;
`endif
    end else begin
      pix.valid_out       <= 1'b0;
      pix.frame_start_out <= 1'b0;
      pix.line_end_out    <= 1'b0;
      pix.sync_err_out    <= 1'b0;

      if (store_s) begin
        pix_r <= pix_next_s;
        if (last_byte_s) begin
          byte_idx_r     <= 2'd0;
          pix.valid_out  <= 1'b1;
          pix.data_out   <= pix_next_s;
          pix.hcount_out <= hcnt_r;
          pix.vcount_out <= vcnt_r;
          hcnt_r         <= hcnt_inc_s;
        end else begin
          byte_idx_r <= byte_idx_r + 2'd1;
        end
      end

      // A partial pixel is simply dropped by restarting at byte 0.
      if (end_line_s) begin
        pix.line_end_out <= 1'b1;
        pix.sync_err_out <= (byte_idx_r != 2'd0);
        byte_idx_r       <= 2'd0;
        hcnt_r           <= '0;
        vcnt_r           <= vcnt_inc_s;
`ifdef CAMERA_DESER_STATS_EN
        pix.line_len_out <= hcnt_r;
`endif
      end

      case (state_r)
        ST_WAIT_FRAME: begin
          if (vs_rise_s) begin
            state_r             <= ST_FRAME;
            pix.frame_start_out <= 1'b1;
            vcnt_r              <= '0;
            hcnt_r              <= '0;
            byte_idx_r          <= 2'd0;
          end
        end
        ST_FRAME: begin
          if (vs_fall_s) begin
            state_r <= ST_WAIT_FRAME;
`ifdef CAMERA_DESER_STATS_EN
            pix.frame_lines_out <= vcnt_r;
`endif
          end else if (store_s) begin
            state_r <= ST_LINE;
          end
        end
        ST_LINE: begin
          if (vs_fall_s) begin
            state_r <= ST_WAIT_FRAME;
`ifdef CAMERA_DESER_STATS_EN
            pix.frame_lines_out <= vcnt_inc_s;
`endif
          end else if (end_line_s) begin
            state_r <= ST_FRAME;
          end
        end
        default: begin
          state_r <= ST_WAIT_FRAME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_deser.sv
// Scoreboard bench: three camera_deser instances (2, 3 and 1 bytes per pixel) share one camera stream.
module tb_camera_deser;

  localparam int NDUT = 3;
  localparam int LAT  = 4;  // SYNC_STAGES + 2
  localparam int BPP  [NDUT] = '{2, 3, 1};
  localparam int HMAX [NDUT] = '{2047, 7, 2047};
  localparam int VMAX = 1023;

  typedef struct {
    int data;
    int h;
    int v;
    int cyc;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pclk, hs, vs;
  logic [7:0] data;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  pix_t pq  [NDUT][$];
  bit   leq [NDUT][$];
  int   fs_exp [NDUT];
  int   fs_got [NDUT];

  // reference model state
  bit m_in_frame, m_in_line, m_armed;
  int m_bidx [NDUT];
  int m_acc  [NDUT];
  int m_hc   [NDUT];
  int m_vc   [NDUT];
  int m_len  [NDUT];
  int m_flines [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  camera_deser_if #(.DATA_W(8), .BYTES_PER_PIX(2), .HCOUNT_W(11), .VCOUNT_W(10)) if0 ();
  camera_deser_if #(.DATA_W(8), .BYTES_PER_PIX(3), .HCOUNT_W(3),  .VCOUNT_W(10)) if1 ();
  camera_deser_if #(.DATA_W(8), .BYTES_PER_PIX(1), .HCOUNT_W(11), .VCOUNT_W(10)) if2 ();

  camera_deser #(.DATA_W(8), .BYTES_PER_PIX(2), .HCOUNT_W(11), .VCOUNT_W(10), .SYNC_STAGES(2)) u0 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs),
    .vs_cam_in(vs), .data_cam_in(data), .pix(if0));
  camera_deser #(.DATA_W(8), .BYTES_PER_PIX(3), .HCOUNT_W(3), .VCOUNT_W(10), .SYNC_STAGES(2)) u1 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs),
    .vs_cam_in(vs), .data_cam_in(data), .pix(if1));
  camera_deser #(.DATA_W(8), .BYTES_PER_PIX(1), .HCOUNT_W(11), .VCOUNT_W(10), .SYNC_STAGES(2)) u2 (
    .clk_pixel_in(clk), .rst_in(rst), .pclk_cam_in(pclk), .hs_cam_in(hs),
    .vs_cam_in(vs), .data_cam_in(data), .pix(if2));

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(int d, logic valid, int dat, int h, int v, logic le, logic se, logic fs);
    pix_t e;
    bit   err;
    if (valid) begin
      if (pq[d].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d unexpected_valid: got pulse expected none (data 0x%0h)", d, dat);
      end else begin
        e = pq[d].pop_front();
        check($sformatf("dut%0d data", d), dat, e.data);
        check($sformatf("dut%0d hcount", d), h, e.h);
        check($sformatf("dut%0d vcount", d), v, e.v);
        check($sformatf("dut%0d latency", d), cyc - e.cyc, LAT);
      end
    end
    if (le) begin
      if (leq[d].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d unexpected_line_end: got pulse expected none", d);
      end else begin
        err = leq[d].pop_front();
        check($sformatf("dut%0d sync_err", d), int'(se), int'(err));
      end
    end else if (se) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d sync_err_alone: got pulse expected none", d);
    end
    if (fs) fs_got[d]++;
  endtask

  always @(negedge clk) if (!rst) mon(0, if0.valid_out, int'(if0.data_out), int'(if0.hcount_out),
    int'(if0.vcount_out), if0.line_end_out, if0.sync_err_out, if0.frame_start_out);
  always @(negedge clk) if (!rst) mon(1, if1.valid_out, int'(if1.data_out), int'(if1.hcount_out),
    int'(if1.vcount_out), if1.line_end_out, if1.sync_err_out, if1.frame_start_out);
  always @(negedge clk) if (!rst) mon(2, if2.valid_out, int'(if2.data_out), int'(if2.hcount_out),
    int'(if2.vcount_out), if2.line_end_out, if2.sync_err_out, if2.frame_start_out);

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_byte(int b);
    pix_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (m_bidx[d] == 0) m_acc[d] = 0;
      m_acc[d] = m_acc[d] * 256 + b;
      m_bidx[d]++;
      if (m_bidx[d] == BPP[d]) begin
        e.data = m_acc[d];
        e.h    = min_i(m_hc[d], HMAX[d]);
        e.v    = min_i(m_vc[d], VMAX);
        e.cyc  = cyc;
        pq[d].push_back(e);
        m_hc[d]++;
        m_bidx[d] = 0;
      end
    end
  endtask

  task automatic model_line_end();
    for (int d = 0; d < NDUT; d++) begin
      leq[d].push_back(m_bidx[d] != 0);
      m_len[d]  = min_i(m_hc[d], HMAX[d]);
      m_bidx[d] = 0;
      m_hc[d]   = 0;
      m_vc[d]++;
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // One camera pclk period: data/hs set while pclk is low, then a rising edge.
  task automatic cam_edge(int b, bit h);
    pclk = 1'b0;
    hs   = h;
    data = 8'(b);
    tick(3);
    pclk = 1'b1;
    if (m_in_frame) begin
      if (h) begin
        m_in_line = 1'b1;
        model_byte(b);
      end else if (m_in_line) begin
        model_line_end();
        m_in_line = 1'b0;
      end
    end
    tick(3);
  endtask

  task automatic set_vs(bit v);
    vs = v;
    if (v) begin
      if (m_armed && !m_in_frame) begin
        m_in_frame = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
          fs_exp[d]++;
          m_vc[d] = 0;
          m_hc[d] = 0;
          m_bidx[d] = 0;
        end
      end
    end else begin
      hs = 1'b0;
      if (m_in_line) model_line_end();
      if (m_in_frame) begin
        for (int d = 0; d < NDUT; d++) m_flines[d] = min_i(m_vc[d], VMAX);
      end
      m_in_line  = 1'b0;
      m_in_frame = 1'b0;
      m_armed    = 1'b1;
    end
    tick(8);
  endtask

  task automatic blanks(int n);
    for (int i = 0; i < n; i++) cam_edge(0, 1'b0);
  endtask

  task automatic rand_bytes(int n);
    for (int i = 0; i < n; i++) cam_edge(int'($urandom_range(0, 255)), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int line_a [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    int nl, n;
    bit ended;
    rst = 1'b1; pclk = 1'b0; hs = 1'b0; vs = 1'b0; data = 8'h00;
    m_in_frame = 1'b0; m_in_line = 1'b0; m_armed = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      fs_exp[d] = 0; fs_got[d] = 0; m_bidx[d] = 0; m_acc[d] = 0;
      m_hc[d] = 0; m_vc[d] = 0; m_len[d] = 0; m_flines[d] = 0;
    end
    tick(3);
    check("reset valid", int'(if0.valid_out), 0);
    check("reset data", int'(if0.data_out), 0);
    check("reset hcount", int'(if0.hcount_out), 0);
    check("reset vcount", int'(if0.vcount_out), 0);
    check("reset frame_start", int'(if0.frame_start_out), 0);
    check("reset line_end", int'(if0.line_end_out), 0);
    check("reset data bpp3", int'(if1.data_out), 0);
    rst = 1'b0;
    tick(8);
    m_armed = 1'b1;

    // frame 1: directed lines, short line with partial pixel, long saturating line
    set_vs(1'b1);
    blanks(2);
    foreach (line_a[i]) cam_edge(line_a[i], 1'b1);
    blanks(2);
    cam_edge(8'hAA, 1'b1); cam_edge(8'hBB, 1'b1); cam_edge(8'hCC, 1'b1);
    rand_bytes(9);
    blanks(2);
    rand_bytes(5);
    blanks(2);
    rand_bytes(30);
    blanks(2);
    set_vs(1'b0);

    // frame 2: three lines of four 2-byte pixels
    set_vs(1'b1);
    blanks(2);
    for (int l = 0; l < 3; l++) begin
      rand_bytes(8);
      blanks(2);
    end
    set_vs(1'b0);
`ifdef CAMERA_DESER_STATS_EN
    check("stats line_len", int'(if0.line_len_out), m_len[0]);
    check("stats frame_lines", int'(if0.frame_lines_out), m_flines[0]);
`endif

    // frame 3: reset mid-line, released with vs still high
    set_vs(1'b1);
    blanks(2);
    rand_bytes(3);
    tick(8);
    rst = 1'b1;
    m_in_frame = 1'b0; m_in_line = 1'b0; m_armed = 1'b0;
    tick(2);
    check("mid-reset valid", int'(if0.valid_out), 0);
    check("mid-reset vcount", int'(if0.vcount_out), 0);
    rst = 1'b0;
    rand_bytes(6);
    blanks(2);
    set_vs(1'b0);

    // random frames, sometimes ending with vs falling inside a line
    for (int f = 0; f < 4; f++) begin
      set_vs(1'b1);
      blanks(2);
      nl = int'($urandom_range(1, 3));
      ended = 1'b0;
      for (int l = 0; l < nl; l++) begin
        n = int'($urandom_range(1, 12));
        rand_bytes(n);
        if (l == nl - 1 && $urandom_range(0, 1) == 1) begin
          set_vs(1'b0);
          ended = 1'b1;
        end else begin
          blanks(2);
        end
      end
      if (!ended) set_vs(1'b0);
    end

    tick(20);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("dut%0d pending pixels", d), pq[d].size(), 0);
      check($sformatf("dut%0d pending line ends", d), leq[d].size(), 0);
      check($sformatf("dut%0d frame_start count", d), fs_got[d], fs_exp[d]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
